dir_command_queue: RTL and testbench
====================================

// Module: dir_command_queue
// PURPOSE
//  Buffers debounced direction-button pulses into a small FIFO of accepted turns and
//  releases one turn per game tick. Sits between the Debouncer instances and the snake
//  movement logic, so fast multi-key sequences (e.g. UP then LEFT within one tick) are
//  not lost. Rejects reversals and duplicates against the last queued direction.
// PARAMETERS
//  DEPTH     4   queue entries; power of two, 2..16
//  DIR_BITS  `BITS_PER_DIR  width of a direction code; encodings are `DIR_UP/DOWN/LEFT/RIGHT
// PORTS
//  Clock         in   1         system clock (same domain as Debouncer outputs)
//  ResetN        in   1         synchronous, active-low reset
//  LeftPressed   in   1         1-cycle pulse from the left debouncer
//  RightPressed  in   1         1-cycle pulse from the right debouncer
//  UpPressed     in   1         1-cycle pulse from the up debouncer
//  DownPressed   in   1         1-cycle pulse from the down debouncer
//  Restart       in   1         1-cycle pulse: flush queue, direction back to `DIR_RIGHT
//  Tick          in   1         1-cycle game-step strobe: consume one queued turn
//  CurDir        out  DIR_BITS  direction to use for the current/next move
//  Count         out  clog2(DEPTH)+1  number of queued turns, 0..DEPTH
//  Dropped       out  1         1-cycle pulse: accepted-class press lost because queue full
// BEHAVIOUR
//  - Reset (ResetN=0 at posedge): CurDir=`DIR_RIGHT, Count=0, pointers=0, Dropped=0.
//  - Press select: multiple pulses same cycle -> priority Left > Right > Up > Down;
//    lower-priority pulses that cycle are discarded (not queued, no Dropped).
//  - Reference dir Ref = tail entry if Count>0, else CurDir (pre-update value).
//  - Candidate rejected silently if == Ref or is the opposite of Ref.
//  - Accepted candidate pushed at tail if Count<DEPTH (or Count==DEPTH and Tick pops
//    this cycle); otherwise discarded and Dropped=1 for exactly that cycle.
//  - Tick with Count>0: CurDir <= head entry, head advances; visible next cycle (latency 1).
//  - Tick with Count==0: CurDir holds.
//  - Push+pop same cycle: both occur; Count unchanged; Ref still the pre-pop tail.
//  - Push+Tick with Count==0: entry queued, CurDir unchanged (applied at a later Tick);
//    see DIR_QUEUE_BYPASS_EN.
//  - Restart: highest priority below ResetN; flushes queue (Count=0), CurDir=`DIR_RIGHT,
//    same-cycle presses and Tick ignored, Dropped=0.
//  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH; Count never exceeds DEPTH and
//    never underflows.
//  - Reset or Restart mid-sequence discards all queued turns; no partial state survives.
//  - All outputs registered; no combinational path from inputs to outputs.
// CONFIGURATION
//  DIR_QUEUE_BYPASS_EN defined: when Count==0 and an accepted press coincides with Tick,
//    CurDir <= candidate directly (not queued); Count stays 0.
//  Not defined: the press is queued as above; CurDir changes only at the next Tick.
// TESTING
//  1 Reset: ResetN=0 one cycle -> CurDir=`DIR_RIGHT, Count=0, Dropped=0.
//  2 UpPressed, then LeftPressed 3 cycles later, no Tick -> Count=2; Tick -> CurDir=UP,
//    Count=1; Tick -> CurDir=LEFT, Count=0; extra Tick -> CurDir stays LEFT.
//  3 From CurDir=RIGHT, empty: LeftPressed -> rejected, Count=0; RightPressed -> rejected.
//    Queue UP then press DownPressed -> rejected (opposite of tail UP), Count=1.
//  4 DEPTH=4: queue UP,LEFT,DOWN,RIGHT -> Count=4; UpPressed -> Dropped=1 one cycle,
//    Count=4; UpPressed with Tick same cycle -> accepted, Count=4, CurDir=UP.
//  5 Same-cycle LeftPressed+UpPressed, CurDir=DOWN -> only LEFT queued (Count=1).
//  6 Count=3 then Restart with Tick and UpPressed -> Count=0, CurDir=`DIR_RIGHT, Dropped=0;
//    with DIR_QUEUE_BYPASS_EN, empty + UpPressed + Tick -> CurDir=UP next cycle, Count=0.

Source files
------------

// File: rtl/dir_command_queue.sv
// dir_command_queue: FIFO of accepted turns, one released to CurDir per Tick.
// Option DIR_QUEUE_BYPASS_EN: empty queue + accepted press + Tick applies press directly.
`ifndef BITS_PER_DIR
`define BITS_PER_DIR 2
`endif
`ifndef DIR_UP
`define DIR_UP 0
`endif
`ifndef DIR_DOWN
`define DIR_DOWN 1
`endif
`ifndef DIR_LEFT
`define DIR_LEFT 2
`endif
`ifndef DIR_RIGHT
`define DIR_RIGHT 3
`endif

module dir_command_queue #(
   parameter int DEPTH    = 4,
   parameter int DIR_BITS = `BITS_PER_DIR
) (
   input  logic                     Clock,
   input  logic                     ResetN,
   input  logic                     LeftPressed,
   input  logic                     RightPressed,
   input  logic                     UpPressed,
   input  logic                     DownPressed,
   input  logic                     Restart,
   input  logic                     Tick,
   output logic [DIR_BITS-1:0]      CurDir,
   output logic [$clog2(DEPTH):0]   Count,
   output logic                     Dropped
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [DIR_BITS-1:0] UP    = DIR_BITS'(`DIR_UP);
   localparam logic [DIR_BITS-1:0] DOWN  = DIR_BITS'(`DIR_DOWN);
   localparam logic [DIR_BITS-1:0] LEFT  = DIR_BITS'(`DIR_LEFT);
   localparam logic [DIR_BITS-1:0] RIGHT = DIR_BITS'(`DIR_RIGHT);

   logic [DIR_BITS-1:0] mem [DEPTH];
   logic [PTR_W-1:0]    headPtr;
   logic [PTR_W-1:0]    tailPtr;
   logic [PTR_W-1:0]    tailPrev;

   logic                candValid;
   logic [DIR_BITS-1:0] cand;
   logic [DIR_BITS-1:0] refDir;
   logic [DIR_BITS-1:0] refOpp;
   logic                accept;
   logic                full;
   logic                pop;
   logic                push;
   logic                bypass;
   logic                drop;

   always_comb begin
      candValid = 1'b1;
      cand      = RIGHT;
      priority case (1'b1)
         LeftPressed:  cand = LEFT;
         RightPressed: cand = RIGHT;
         UpPressed:    cand = UP;
         DownPressed:  cand = DOWN;
         default:      candValid = 1'b0;
      endcase
   end

   // Reference is the last queued turn, so reversals are judged against intent
   assign tailPrev = tailPtr - PTR_W'(1);
   assign refDir   = (Count != '0) ? mem[tailPrev] : CurDir;

   always_comb begin
      refOpp = refDir;
      if (refDir == UP)
         refOpp = DOWN;
      else if (refDir == DOWN)
         refOpp = UP;
      else if (refDir == LEFT)
         refOpp = RIGHT;
      else if (refDir == RIGHT)
         refOpp = LEFT;
   end

   assign accept = candValid && (cand != refDir) && (cand != refOpp);
   assign full   = (Count == CNT_W'(DEPTH));
   assign pop    = Tick && (Count != '0);

`ifdef DIR_QUEUE_BYPASS_EN
   assign bypass = accept && Tick && (Count == '0);
`else
   assign bypass = 1'b0;
`endif

   assign push = accept && !bypass && (!full || pop);
   assign drop = accept && full && !pop;

   always_ff @(posedge Clock) begin
      if (ResetN && !Restart && push)
         mem[tailPtr] <= cand;
   end

   always_ff @(posedge Clock) begin
      if (!ResetN || Restart) begin
         headPtr <= '0;
         tailPtr <= '0;
         Count   <= '0;
         CurDir  <= RIGHT;
         Dropped <= 1'b0;
      end else begin
         Dropped <= drop;
         if (push)
            tailPtr <= tailPtr + PTR_W'(1);
         if (pop) begin
            CurDir  <= mem[headPtr];
            headPtr <= headPtr + PTR_W'(1);
         end else if (bypass) begin
            CurDir <= cand;
         end
         if (push && !pop)
            Count <= Count + CNT_W'(1);
         else if (pop && !push)
            Count <= Count - CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_dir_command_queue.sv
// tb_dir_command_queue: vector table driven through a one-deep expected-result scoreboard.
// Expectations follow the queue behaviour; DIR_QUEUE_BYPASS_EN selects bypass results.
`ifndef BITS_PER_DIR
`define BITS_PER_DIR 2
`endif
`ifndef DIR_UP
`define DIR_UP 0
`endif
`ifndef DIR_DOWN
`define DIR_DOWN 1
`endif
`ifndef DIR_LEFT
`define DIR_LEFT 2
`endif
`ifndef DIR_RIGHT
`define DIR_RIGHT 3
`endif

module tb_dir_command_queue;

   localparam int DEPTH = 4;
   localparam int DB    = `BITS_PER_DIR;
   localparam int CW    = $clog2(DEPTH) + 1;
   localparam int U = `DIR_UP;
   localparam int D = `DIR_DOWN;
   localparam int L = `DIR_LEFT;
   localparam int R = `DIR_RIGHT;

   typedef struct {
      logic          rstN, l, r, u, d, rs, tk;
      logic [DB-1:0] eDir;
      logic [CW-1:0] eCnt;
      logic          eDrop;
   } vec_t;

   typedef struct {
      int            idx;
      logic [DB-1:0] dir;
      logic [CW-1:0] cnt;
      logic          drop;
   } exp_t;

   logic          clock = 1'b0;
   logic          resetN, left, right, up, down, restart, tick;
   logic [DB-1:0] curDir;
   logic [CW-1:0] count;
   logic          dropped;

   int   compared = 0;
   int   mismatched = 0;
   vec_t vecs[$];
   exp_t sb[$];

   always #5 clock = ~clock;

   dir_command_queue #(.DEPTH(DEPTH), .DIR_BITS(DB)) dut (
      .Clock(clock), .ResetN(resetN),
      .LeftPressed(left), .RightPressed(right),
      .UpPressed(up), .DownPressed(down),
      .Restart(restart), .Tick(tick),
      .CurDir(curDir), .Count(count), .Dropped(dropped)
   );

   task automatic add(input int rn, l, r, u, d, rs, tk, ed, ec, edr);
      vec_t v;
      v.rstN = rn[0]; v.l = l[0]; v.r = r[0]; v.u = u[0];
      v.d = d[0]; v.rs = rs[0]; v.tk = tk[0];
      v.eDir = DB'(ed); v.eCnt = CW'(ec); v.eDrop = edr[0];
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input int idx, input int act, input int req);
      compared++;
      if (act != req) begin
         mismatched++;
         $display("FAIL %s vec %0d: got %0d, required %0d", name, idx, act, req);
      end
   endtask

   task automatic step(input int idx, input vec_t v);
      exp_t e;
      resetN = v.rstN; left = v.l; right = v.r; up = v.u;
      down = v.d; restart = v.rs; tick = v.tk;
      e.idx = idx; e.dir = v.eDir; e.cnt = v.eCnt; e.drop = v.eDrop;
      sb.push_back(e);
      @(posedge clock);
      #1;
      if (sb.size() == 0) begin
         mismatched++;
         $display("FAIL scoreboard vec %0d: got empty, required entry", idx);
      end else begin
         e = sb.pop_front();
         check("CurDir", e.idx, int'(curDir), int'(e.dir));
         check("Count", e.idx, int'(count), int'(e.cnt));
         check("Dropped", e.idx, int'(dropped), int'(e.drop));
      end
   endtask

   initial begin
      resetN = 1'b0; left = 1'b0; right = 1'b0; up = 1'b0;
      down = 1'b0; restart = 1'b0; tick = 1'b0;

      //  rn l r u d rs tk  dir cnt drop
      add(0, 0,0,0,0,0,0, R,0,0);
      add(1, 0,0,0,0,0,0, R,0,0);
      add(1, 0,0,1,0,0,0, R,1,0);
      add(1, 0,0,0,0,0,0, R,1,0);
      add(1, 0,0,0,0,0,0, R,1,0);
      add(1, 1,0,0,0,0,0, R,2,0);
      add(1, 0,0,0,0,0,1, U,1,0);
      add(1, 0,0,0,0,0,1, L,0,0);
      add(1, 0,0,0,0,0,1, L,0,0);
      add(1, 0,0,0,0,1,0, R,0,0);
      add(1, 1,0,0,0,0,0, R,0,0);
      add(1, 0,1,0,0,0,0, R,0,0);
      add(1, 0,0,1,0,0,0, R,1,0);
      add(1, 0,0,0,1,0,0, R,1,0);
      add(1, 1,0,0,0,0,0, R,2,0);
      add(1, 0,0,0,1,0,0, R,3,0);
      add(1, 0,1,0,0,0,0, R,4,0);
      add(1, 0,0,1,0,0,0, R,4,1);
      add(1, 0,0,0,0,0,0, R,4,0);
      add(1, 0,0,1,0,0,1, U,4,0);
      add(1, 0,0,1,0,0,0, U,4,0);
      add(1, 0,0,0,0,0,1, L,3,0);
      add(1, 0,0,0,0,0,1, D,2,0);
      add(1, 0,0,0,0,0,1, R,1,0);
      add(1, 0,0,0,0,0,1, U,0,0);
      add(1, 0,0,0,0,0,1, U,0,0);
      add(1, 1,0,0,0,0,0, U,1,0);
      add(1, 0,0,0,0,0,1, L,0,0);
      add(1, 0,0,0,1,0,0, L,1,0);
      add(1, 0,0,0,0,0,1, D,0,0);
      add(1, 1,0,1,0,0,0, D,1,0);
      add(1, 0,0,0,0,0,1, L,0,0);
      add(1, 0,1,1,1,0,0, L,0,0);
      add(1, 0,0,1,1,0,0, L,1,0);
      add(1, 0,0,0,1,0,0, L,1,0);
      add(1, 0,1,0,1,0,0, L,2,0);
      add(1, 0,0,0,1,0,0, L,3,0);
      add(1, 0,0,1,0,1,1, R,0,0);
      add(1, 0,0,0,0,0,1, R,0,0);
`ifdef DIR_QUEUE_BYPASS_EN
      add(1, 0,0,1,0,0,1, U,0,0);
      add(1, 0,0,0,0,0,1, U,0,0);
`else
      add(1, 0,0,1,0,0,1, R,1,0);
      add(1, 0,0,0,0,0,1, U,0,0);
`endif

      for (int i = 0; i < vecs.size(); i++)
         step(i, vecs[i]);

      // Full queue, then Restart coinciding with a would-be drop
      vecs.delete();
      add(1, 1,0,0,0,0,0, U,1,0);
      add(1, 0,0,0,1,0,0, U,2,0);
      add(1, 0,1,0,0,0,0, U,3,0);
      add(1, 0,0,1,0,0,0, U,4,0);
      add(1, 0,0,0,1,0,0, U,4,0);
      add(1, 1,0,0,0,0,0, U,4,1);
      add(1, 1,0,0,0,1,0, R,0,0);
      // Reset mid-sequence, then push+pop with Ref on the pre-pop tail
      add(1, 0,0,1,0,0,0, R,1,0);
      add(0, 0,0,0,0,0,1, R,0,0);
      add(1, 0,0,0,0,0,1, R,0,0);
      add(1, 0,0,1,0,0,0, R,1,0);
      add(1, 1,0,0,0,0,1, U,1,0);
      add(1, 0,0,0,0,0,1, L,0,0);
      add(1, 0,0,1,0,0,0, L,1,0);
      add(1, 0,0,0,1,0,1, U,0,0);
      add(1, 0,0,0,0,0,0, U,0,0);
      for (int i = 0; i < vecs.size(); i++)
         step(100 + i, vecs[i]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
